// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FULL   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam int unsigned ERR_W = 8;

    // Frame is rw bit, address, then data, MSB first.
    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchroniser for an asynchronous input with edge detection
// between the two oldest stages.
module sync_edge_detect #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [DEPTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {DEPTH{RST_VAL}};
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_d};
        end
    end

    // Level is the newer of the two compared stages so it agrees with the edges.
    assign o_level  = r_sync[DEPTH-2];
    assign o_rise_c = r_sync[DEPTH-2] & ~r_sync[DEPTH-1];
    assign o_fall_c = ~r_sync[DEPTH-2] & r_sync[DEPTH-1];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target exposing a small register bank; writes commit on ncs
// rising edge, reads stream a shadow copy captured after the address phase.
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ncs,
    input  logic                       sclk,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [ERR_W-1:0]           err_count
);

    localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned HDR_W   = 1 + ADDR_W;

    logic w_ncs_lvl, w_ncs_rise, w_ncs_fall;
    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_copi, w_copi_rise, w_copi_fall;
    logic w_unused;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [FRAME_W-1:0]  r_shift, w_shift_nxt;
    logic [DATA_W-1:0]   r_shadow, w_rd_val;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                r_rd, r_cipo, r_cipo_oe, r_wr_strobe;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ERR_W-1:0]    r_err;
    logic                w_start, w_shift_en, w_abort, w_commit;
    logic [ADDR_W-1:0]   w_hdr_addr, w_cmt_addr;
    logic                w_cmt_hit;

    sync_edge_detect #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .i_d(ncs),
        .o_level(w_ncs_lvl), .o_rise_c(w_ncs_rise), .o_fall_c(w_ncs_fall)
    );

    sync_edge_detect #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_d(sclk),
        .o_level(w_sclk_lvl), .o_rise_c(w_sclk_rise), .o_fall_c(w_sclk_fall)
    );

    sync_edge_detect #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .i_d(copi),
        .o_level(w_copi), .o_rise_c(w_copi_rise), .o_fall_c(w_copi_fall)
    );

    assign w_unused = ^{w_sclk_lvl, w_copi_rise, w_copi_fall};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An ncs rise is checked before sclk so a coincident sclk edge is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_abort     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ncs_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_ncs_rise) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_sclk_rise && !w_ncs_lvl) begin
                    w_shift_en = 1'b1;
                    if (r_cnt == CNT_W'(FRAME_W - 1)) begin
                        w_state_nxt = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (w_ncs_rise) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_shift_nxt = {r_shift[FRAME_W-2:0], w_copi};
    assign w_hdr_addr  = w_shift_nxt[ADDR_W-1:0];
    assign w_cmt_addr  = r_shift[DATA_W +: ADDR_W];
    assign w_cmt_hit   = r_shift[FRAME_W-1] && (32'(w_cmt_addr) < NUM_REGS);

    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (32'(w_hdr_addr) == 32'(k)) begin
                w_rd_val = r_regs[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_shadow    <= '0;
            r_rd        <= 1'b0;
            r_cipo      <= 1'b0;
            r_cipo_oe   <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_err       <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_start) begin
                r_cnt    <= '0;
                r_shift  <= '0;
                r_shadow <= '0;
                r_rd     <= 1'b0;
            end
            if (w_shift_en) begin
                r_shift <= w_shift_nxt;
                r_cnt   <= r_cnt + 1'b1;
                // Header complete on a read: snapshot the addressed register.
                if (r_cnt == CNT_W'(HDR_W - 1) && !w_shift_nxt[ADDR_W]) begin
                    r_shadow <= w_rd_val;
                    r_rd     <= 1'b1;
                end
            end
            if (r_state == ST_SHIFT && !w_ncs_rise && w_sclk_fall && r_rd) begin
                r_cipo    <= r_shadow[DATA_W-1];
                r_shadow  <= r_shadow << 1;
                r_cipo_oe <= 1'b1;
            end
            if (w_ncs_rise) begin
                r_cipo    <= 1'b0;
                r_cipo_oe <= 1'b0;
            end
            if (w_abort && r_err != 8'hFF) begin
                r_err <= r_err + 8'd1;
            end
            if (w_commit && w_cmt_hit) begin
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= w_cmt_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_commit && w_cmt_hit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (32'(w_cmt_addr) == 32'(k)) begin
                    r_regs[k] <= r_shift[DATA_W-1:0];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign cipo      = r_cipo;
    assign cipo_oe   = r_cipo_oe;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign err_count = r_err;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench: stimulus pushes expected writes/reads from a register-array
// model; independent monitors pop on wr_strobe and on completed read frames.
`timescale 1ns/1ps
module tb_spi_regfile_peripheral;

    localparam int NR  = 5;
    localparam int AW  = 7;
    localparam int DW  = 8;
    localparam int FW  = 1 + AW + DW;
    localparam int NR2 = 8;
    localparam int AW2 = 3;
    localparam int DW2 = 16;
    localparam int FW2 = 1 + AW2 + DW2;
    localparam int HP  = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ncs = 1'b1;
    logic ncs2 = 1'b1;
    logic sclk = 1'b0;
    logic copi = 1'b0;

    logic              cipo, cipo_oe, wr_strobe;
    logic [NR*DW-1:0]  regs;
    logic [AW-1:0]     wr_addr;
    logic [7:0]        err_count;
    logic              cipo2, cipo_oe2, wr_strobe2;
    logic [NR2*DW2-1:0] regs2;
    logic [AW2-1:0]    wr_addr2;
    logic [7:0]        err_count2;

    spi_regfile_peripheral u_dut (
        .clk(clk), .rst(rst), .ncs(ncs), .sclk(sclk), .copi(copi),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs(regs), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .err_count(err_count)
    );

    spi_regfile_peripheral #(.NUM_REGS(NR2), .ADDR_W(AW2), .DATA_W(DW2)) u_dut2 (
        .clk(clk), .rst(rst), .ncs(ncs2), .sclk(sclk), .copi(copi),
        .cipo(cipo2), .cipo_oe(cipo_oe2), .regs(regs2), .wr_strobe(wr_strobe2),
        .wr_addr(wr_addr2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             wr;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    data;
        logic [NR*DW-1:0] snap;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_regs [128];
    int            m_err;
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_str2 = 0;

    always @(posedge clk) if (wr_strobe2 === 1'b1) n_str2 <= n_str2 + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] snap_f();
        logic [NR*DW-1:0] s;
        for (int k = 0; k < NR; k++) s[k*DW +: DW] = m_regs[k];
        return s;
    endfunction

    task automatic spi_bit(input int sel, input logic b, output logic rb);
        copi = b;
        #HP;
        sclk = 1'b1;
        rb = (sel == 2) ? cipo2 : cipo;
        #HP;
        sclk = 1'b0;
    endtask

    task automatic spi_xfer(input int sel, input logic [31:0] frame, input int fw,
                            input int nsent, input int extra, output logic [31:0] rx);
        logic rb;
        rx = '0;
        if (sel == 2) ncs2 = 1'b0; else ncs = 1'b0;
        #HP;
        for (int i = 0; i < nsent; i++) begin
            spi_bit(sel, frame[fw-1-i], rb);
            rx = {rx[30:0], rb};
        end
        for (int i = 0; i < extra; i++) spi_bit(sel, 1'b0, rb);
        #HP;
        if (sel == 2) ncs2 = 1'b1; else ncs = 1'b1;
        repeat (12) @(posedge clk);
    endtask

    // Model: full writes in range update the array; full reads expect the array
    // value (or 0 out of range); short frames bump the saturating error count.
    task automatic issue(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int nsent, input int extra);
        exp_t e;
        logic [31:0] rx;
        if (nsent >= FW) begin
            if (rw && int'(addr) < NR) begin
                m_regs[addr] = data;
                e.wr = 1'b1; e.addr = addr; e.data = data; e.snap = snap_f();
                exp_q.push_back(e);
            end else if (!rw) begin
                e.wr = 1'b0; e.addr = addr;
                e.data = (int'(addr) < NR) ? m_regs[addr] : '0;
                e.snap = snap_f();
                exp_q.push_back(e);
            end
        end else if (m_err < 255) begin
            m_err++;
        end
        spi_xfer(1, {16'h0, rw, addr, data}, FW, nsent, extra, rx);
        check("err_count", err_count, 64'(m_err));
        check("regs_after_frame", regs, snap_f());
    endtask

    initial begin : mon_wr
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr_strobe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL wr_unexpected: got strobe addr 0x%0h, expected no strobe", wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_kind", 64'(e.wr), 64'(1));
                    check("wr_addr", wr_addr, e.addr);
                    check("regs_at_strobe", regs, e.snap);
                end
                @(negedge clk);
                check("strobe_width", wr_strobe, 0);
            end
        end
    end

    initial begin : mon_spi
        int nb;
        logic rw;
        logic [DW-1:0] rx;
        exp_t e;
        forever begin
            @(negedge ncs);
            nb = 0; rw = 1'b1; rx = '0;
            while (ncs == 1'b0) begin
                @(posedge sclk or posedge ncs);
                if (ncs == 1'b0) begin
                    if (nb == 0) rw = copi;
                    if (!rw && nb >= 1 + AW) begin
                        check("cipo_oe_data", cipo_oe, 1);
                        if (nb < FW) rx = {rx[DW-2:0], cipo};
                    end else begin
                        check("cipo_idle", {cipo_oe, cipo}, 0);
                    end
                    nb++;
                end
            end
            if (nb >= FW && !rw) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rd_unexpected: got read data 0x%0h, expected no entry", rx);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_kind", 64'(e.wr), 64'(0));
                    check("rd_data", rx, e.data);
                end
            end
            repeat (4) @(negedge clk);
            check("cipo_release", {cipo_oe, cipo}, 0);
        end
    end

    initial begin : main
        logic [31:0] rx2;
        logic [15:0] f;
        logic rb, rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int kind;
        for (int k = 0; k < 128; k++) m_regs[k] = '0;
        m_err = 0;

        repeat (4) @(posedge clk);
        #1;
        check("rst_regs", regs, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_err", err_count, 0);
        check("rst_cipo", {cipo_oe, cipo}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        issue(1'b1, 7'd2, 8'hA5, FW, 0);
        issue(1'b0, 7'd2, 8'h00, FW, 0);
        issue(1'b1, 7'd1, 8'hFF, 10, 0);
        issue(1'b1, 7'd1, 8'hFF, FW, 0);
        issue(1'b1, 7'h7F, 8'h33, FW, 0);
        issue(1'b1, 7'd4, 8'h11, FW, 3);
        issue(1'b0, 7'd4, 8'h00, FW, 2);
        issue(1'b0, 7'h7F, 8'h00, FW, 0);

        // Reset in the middle of a write frame.
        f = 16'h8122;
        ncs = 1'b0;
        #HP;
        for (int i = 0; i < 8; i++) spi_bit(1, f[15-i], rb);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        ncs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_regs", regs, 0);
        check("midrst_err", err_count, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_cipo", {cipo_oe, cipo, wr_strobe}, 0);
        for (int k = 0; k < 128; k++) m_regs[k] = '0;
        m_err = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        issue(1'b1, 7'd1, 8'h22, FW, 0);

        repeat (40) begin
            rw   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
            data = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      issue(rw, addr, data, int'($urandom_range(0, FW - 1)), 0);
            else if (kind == 1) issue(rw, addr, data, FW, int'($urandom_range(1, 3)));
            else                issue(rw, addr, data, FW, 0);
        end

        repeat (260) issue(1'b1, 7'd0, 8'h00, 1, 0);
        check("err_saturated", err_count, 8'hFF);
        issue(1'b1, 7'd3, 8'h5A, FW, 0);

        spi_xfer(2, 32'h000FBEEF, FW2, FW2, 0, rx2);
        check("p2_reg7", regs2[7*DW2 +: DW2], 16'hBEEF);
        check("p2_wr_addr", wr_addr2, 3'd7);
        check("p2_strobes", 64'(n_str2), 64'(1));
        spi_xfer(2, 32'h00070000, FW2, FW2, 0, rx2);
        check("p2_readback", rx2[15:0], 16'hBEEF);
        check("p2_other_regs", regs2[7*DW2-1:0], 0);
        check("p2_err", err_count2, 0);
        check("p2_oe_idle", {cipo_oe2, cipo2}, 0);
        check("p2_strobes_after_read", 64'(n_str2), 64'(1));
        check("sb_drained", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_regfile_peripheral.md
SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

Interface
REQ-001 SHALL have parameter NUM_REGS, default 5: number of writable/readable registers.
REQ-002 SHALL have parameter ADDR_W, default 7: address field width.
REQ-003 SHALL have parameter DATA_W, default 8: register and data field width.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth, minimum 2.
REQ-005 SHALL have port clk, input, 1: single system clock. All logic is in this domain.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port ncs, input, 1: SPI chip select, active low, asynchronous.
REQ-008 SHALL have port sclk, input, 1: SPI clock, mode 0, asynchronous.
REQ-009 SHALL have port copi, input, 1: controller-out data, sampled on the sclk rising edge.
REQ-010 SHALL have port cipo, output, 1: controller-in data, driven on the sclk falling edge.
REQ-011 SHALL have port cipo_oe, output, 1: high while cipo carries read data.
REQ-012 SHALL have port regs, output, NUM_REGS*DATA_W: flat register bank, with reg k at bits [k*DATA_W +: DATA_W].
REQ-013 SHALL have port wr_strobe, output, 1: one-clk pulse on each committed write.
REQ-014 SHALL have port wr_addr, output, ADDR_W: address of the last committed write.
REQ-015 SHALL have port err_count, output, 8: saturating count of aborted frames.

Function
REQ-016 SHALL pass ncs, sclk and copi through SYNC_STAGES flip-flops each, with edge detection on the last two stages; clk SHALL be at least 4x sclk.
REQ-017 SHALL use frame format FRAME_W = 1+ADDR_W+DATA_W bits, MSB first: rw bit (1 = write), then address, then data.
REQ-018 SHALL implement an FSM with states IDLE, SHIFT, FULL, COMMIT:
  - IDLE -> SHIFT on a synced ncs falling edge; this transition clears the bit counter and shift register.
REQ-019 In SHIFT, each synced sclk rising edge with ncs low SHALL shift in copi and increment the counter; reaching FRAME_W SHALL transition to FULL.
REQ-020 In FULL, further sclk edges SHALL be ignored; a synced ncs rising edge SHALL transition to COMMIT.
REQ-021 In SHIFT, a synced ncs rising edge SHALL return the FSM to IDLE with no register change and err_count incremented, saturating at 255.
REQ-022 COMMIT SHALL last one clk, then go to IDLE:
  - write with addr < NUM_REGS: update reg[addr], pulse wr_strobe and set wr_addr, all in the same clk;
  - write with addr >= NUM_REGS: no effect and no strobe;
  - read: no register effect.
REQ-023 Read, load: when the counter reaches 1+ADDR_W, the block SHALL load a DATA_W shadow register with reg[addr], or 0 if addr is out of range.
REQ-024 Read, drive: on each subsequent synced sclk falling edge the block SHALL drive the shadow MSB on cipo and then shift the shadow.
REQ-025 cipo_oe SHALL be high from the first data-phase falling edge until ncs rises; cipo SHALL be 0 whenever cipo_oe is low.
REQ-026 When a synced ncs rising edge and a synced sclk rising edge occur in the same clk, the ncs edge SHALL win and the sclk edge SHALL be dropped.
REQ-027 Register contents SHALL change only in COMMIT; a write frame SHALL never alter the shadow of a read in progress.

Reset
REQ-028 Asserting rst SHALL immediately set:
  - all regs, shift register, counter, shadow, wr_addr and err_count to 0;
  - wr_strobe, cipo and cipo_oe low;
  - FSM to IDLE;
  - all synchroniser stages to 1 (ncs idle high) or 0 (sclk, copi).
REQ-029 On rst assertion mid-frame, the frame SHALL be discarded; after release, the block SHALL wait for a fresh ncs falling edge.

Structure
REQ-030 A shared package spi_regfile_pkg SHALL hold the FSM state enum and a FRAME_W helper function.
REQ-031 A sub-module sync_edge_detect (parametrised depth and reset value, outputs level/rise/fall) SHALL be instantiated for ncs, sclk and copi.

Verification (defaults unless stated)
REQ-032 Write frame 0x82A5 -> regs[2]=0xA5 one clk after COMMIT, a single wr_strobe pulse, wr_addr=2.
REQ-033 Then read frame 0x0200 -> cipo shifts out 1010_0101 across the data phase, cipo_oe high throughout, regs unchanged.
REQ-034 ncs raised after 10 bits of 0x81FF -> regs[1] stays 0, err_count=1, no strobe; next full frame commits normally.
REQ-035 Write 0xFF33 (addr 0x7F) plus 3 extra sclk pulses on 0x8411 -> addr 0x7F: no change, no strobe; extra pulses ignored and regs[4]=0x11.
REQ-036 rst pulsed mid-frame after 8 bits -> all outputs 0; the following complete write 0x8122 -> regs[1]=0x22.
REQ-037 With NUM_REGS=8, ADDR_W=3, DATA_W=16: write 0xFBEEF (addr 7) -> regs[7]=0xBEEF; read-back returns 0xBEEF.
